// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store port responder for the RV32I core.
// Word RAM with byte/half/word access behind programmable wait states.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam bit ZW = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_error;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_idle;
  logic          w_accept;
  logic          w_exec;
  logic          w_write;
  logic [2:0]    w_f3;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;
  logic [31:0]   w_rdata;
  logic [3:0]    w_be;
  logic [31:0]   w_wal;
  logic          w_we;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle & req_valid;

  // With no wait states the request executes in its accept cycle,
  // so the live inputs stand in for the not-yet-latched copy.
  assign w_write = w_idle ? req_write  : r_write;
  assign w_f3    = w_idle ? req_funct3 : r_funct3;
  assign w_addr  = w_idle ? req_addr   : r_addr;
  assign w_wdata = w_idle ? req_wdata  : r_wdata;

  // Execute strobe: the cycle whose edge moves the FSM into RESP.
  always_comb begin
    if (ZW) w_exec = w_accept;
    else    w_exec = (r_state == S_WAIT) && (r_cnt == CW'(1));
  end

  // Alignment, funct3 legality and range check.
  always_comb begin
    w_err = 1'b0;
    unique case (w_f3)
      3'b000:  w_err = 1'b0;
      3'b001:  w_err = w_addr[0];
      3'b010:  w_err = (w_addr[1:0] != 2'b00);
      3'b100:  w_err = w_write;
      3'b101:  w_err = w_write | w_addr[0];
      default: w_err = 1'b1;
    endcase
    if (w_addr[31:2] >= 30'(DEPTH_WORDS)) w_err = 1'b1;
  end

  assign w_idx   = w_addr[AW+1:2];
  assign w_rword = r_mem[w_idx];

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    w_byte = 8'h00;
    unique case (w_addr[1:0])
      2'b00: w_byte = w_rword[7:0];
      2'b01: w_byte = w_rword[15:8];
      2'b10: w_byte = w_rword[23:16];
      2'b11: w_byte = w_rword[31:24];
    endcase
    w_half = w_addr[1] ? w_rword[31:16] : w_rword[15:0];
    w_load = 32'h0;
    unique case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_rword;
      3'b100:  w_load = {24'h0, w_byte};
      3'b101:  w_load = {16'h0, w_half};
      default: w_load = 32'h0;
    endcase
    w_rdata = (w_err | w_write) ? 32'h0 : w_load;
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    w_be  = 4'b0000;
    w_wal = 32'h0;
    unique case (w_f3[1:0])
      2'b00: begin
        w_be  = 4'b0001 << w_addr[1:0];
        w_wal = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be  = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wal = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_be  = 4'b1111;
        w_wal = w_wdata;
      end
      default: begin
        w_be  = 4'b0000;
        w_wal = 32'h0;
      end
    endcase
  end

  assign w_we = w_exec & w_write & ~w_err;

  // RAM byte-lane write; contents survive reset, reset blocks the write.
  always_ff @(posedge clk) begin
    if (reset && w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wal[8*b +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_error <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_req_ready <= 1'b0;
            if (ZW) begin
              r_state     <= S_RESP;
              r_cnt       <= '0;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata;
              r_rsp_error <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= CW'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_error <= w_err;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_error <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_error <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder.
// Two instances: two wait states and zero wait states.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid2 = 1'b0;
  logic        req_valid0 = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b1;

  logic        req_ready2, rsp_valid2, rsp_error2;
  logic [31:0] rsp_rdata2;
  logic        req_ready0, rsp_valid0, rsp_error0;
  logic [31:0] rsp_rdata0;

  int n_chk = 0;
  int n_fail = 0;

  logic [32:0] q2[$];
  logic [32:0] q0[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid2), .req_ready(req_ready2),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata2), .rsp_error(rsp_error2)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected response on every response handshake.
  always @(negedge clk) begin
    if (rsp_valid2 && rsp_ready) begin
      if (q2.size() == 0) begin
        chk("dut2 unexpected rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = q2.pop_front();
        chk("dut2 rdata", rsp_rdata2, e[31:0]);
        chk("dut2 error", {31'h0, rsp_error2}, {31'h0, e[32]});
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid0 && rsp_ready) begin
      if (q0.size() == 0) begin
        chk("dut0 unexpected rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = q0.pop_front();
        chk("dut0 rdata", rsp_rdata0, e[31:0]);
        chk("dut0 error", {31'h0, rsp_error0}, {31'h0, e[32]});
      end
    end
  end

  task automatic do_req(input bit sel, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input bit ee,
                        input int hold);
    int n;
    bit got;
    @(posedge clk); #1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rsp_ready  = (hold == 0);
    if (sel) q0.push_back({ee, er});
    else     q2.push_back({ee, er});
    @(negedge clk);
    chk("req_ready idle", {31'h0, sel ? req_ready0 : req_ready2}, 32'd1);
    if (sel) req_valid0 = 1'b1;
    else     req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    req_valid2 = 1'b0;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h0BAD_0BAD;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      chk("req_ready busy", {31'h0, sel ? req_ready0 : req_ready2}, 32'd0);
      if (sel ? rsp_valid0 : rsp_valid2) got = 1'b1;
    end
    if (!got) begin
      chk("rsp timeout", 32'd1, 32'd0);
      rsp_ready = 1'b1;
      return;
    end
    chk("latency", n, sel ? 32'd1 : 32'd3);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold valid", {31'h0, sel ? rsp_valid0 : rsp_valid2}, 32'd1);
        chk("hold rdata", sel ? rsp_rdata0 : rsp_rdata2, er);
        chk("hold ready", {31'h0, sel ? req_ready0 : req_ready2}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    chk("post valid", {31'h0, sel ? rsp_valid0 : rsp_valid2}, 32'd0);
    chk("post ready", {31'h0, sel ? req_ready0 : req_ready2}, 32'd1);
    chk("post rdata", sel ? rsp_rdata0 : rsp_rdata2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst req_ready2", {31'h0, req_ready2}, 32'd1);
    chk("rst req_ready0", {31'h0, req_ready0}, 32'd1);
    chk("rst rsp_valid2", {31'h0, rsp_valid2}, 32'd0);
    chk("rst rsp_rdata2", rsp_rdata2, 32'd0);
    chk("rst rsp_error2", {31'h0, rsp_error2}, 32'd0);

    do_req(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    do_req(0, 1, 3'b000, 32'h11, 32'h000000A5, 32'h0, 0, 0);
    do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 0, 0);
    do_req(0, 0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFA5, 0, 0);
    do_req(0, 0, 3'b100, 32'h11, 32'h0, 32'h000000A5, 0, 0);
    do_req(0, 1, 3'b001, 32'h12, 32'h00008001, 32'h0, 0, 0);
    do_req(0, 0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 0, 0);
    do_req(0, 0, 3'b101, 32'h12, 32'h0, 32'h00008001, 0, 0);
    do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'h8001A5EF, 0, 0);

    do_req(0, 0, 3'b010, 32'h13, 32'h0, 32'h0, 1, 0);
    do_req(0, 1, 3'b001, 32'h11, 32'hFFFFFFFF, 32'h0, 1, 0);
    do_req(0, 1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1, 0);
    do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'h8001A5EF, 0, 0);
    do_req(0, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 0);
    do_req(0, 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0);

    do_req(0, 1, 3'b010, 32'hFFC, 32'h11223344, 32'h0, 0, 0);
    do_req(0, 0, 3'b000, 32'hFFF, 32'h0, 32'h00000011, 0, 0);
    do_req(0, 0, 3'b101, 32'hFFE, 32'h0, 32'h00001122, 0, 0);

    do_req(0, 0, 3'b010, 32'h10, 32'h0, 32'h8001A5EF, 0, 5);
    do_req(1, 1, 3'b010, 32'h40, 32'h55AA55AA, 32'h0, 0, 5);
    do_req(1, 0, 3'b010, 32'h40, 32'h0, 32'h55AA55AA, 0, 5);
    do_req(1, 0, 3'b000, 32'h41, 32'h0, 32'h00000055, 0, 0);

    do_req(0, 1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    @(posedge clk); #1;
    req_write  = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    rsp_ready  = 1'b1;
    req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid-rst rsp_valid", {31'h0, rsp_valid2}, 32'd0);
    chk("mid-rst req_ready", {31'h0, req_ready2}, 32'd1);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid2) bad = 1'b1;
    end
    chk("dropped store rsp", {31'h0, bad}, 32'd0);
    do_req(0, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);

    repeat (3) @(posedge clk);
    chk("q2 drained", q2.size(), 32'd0);
    chk("q0 drained", q0.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder serving the load/store port of the RV32I core: accepts one request at a time over a valid/ready handshake, performs a byte, half or word access on an internal word-addressed RAM after a programmable number of wait states, and returns load data or an error over a second valid/ready handshake. It sits on the memory side of the datapath's ALU-computed address and `rd2` store data, and lets the core be tested against non-zero memory latency.

## Interface
- DEPTH_WORDS, 1024, RAM size in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 allowed)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low: sampled on rising clk edge, 0 = reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- rsp_error  out  1  request rejected (misaligned, illegal funct3, out of range)

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid=1, latch write/funct3/addr/wdata. Go to WAIT with counter=WAIT_CYCLES, or straight to RESP if WAIT_CYCLES=0.
- WAIT: counter decrements each cycle. On the cycle it equals 1, go to RESP.
- Execute on the transition into RESP, using the latched request:
  - Error check: half access with addr[0]=1, word access with addr[1:0]!=0, funct3 in {011,110,111}, store with funct3[2]=1, or addr[31:2] >= DEPTH_WORDS. Error gives rsp_error=1, rsp_rdata=0, RAM unchanged.
  - Loads: word = RAM[addr[31:2]]. Byte lane = addr[1:0]; half lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
  - Stores: write only the selected byte lanes. SB writes wdata[7:0] into lane addr[1:0]; SH writes wdata[15:0] into half addr[1]; SW writes the full word. Other lanes are preserved.
  - rsp_rdata=0 for stores.
- RESP: rsp_valid=1. rsp_rdata and rsp_error are held stable until rsp_ready=1. On the handshake, go to IDLE and clear rsp_valid, rsp_rdata and rsp_error.
- One outstanding request. The core must not issue a new request in the same cycle as a RESP handshake.
- RAM contents are not reset. Read-before-write is not visible, because each request completes before the next is accepted.

## Timing
- Reset (reset=0 at an edge) forces IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_error=0. req_ready=1 from the first cycle after release.
- Request accepted at edge A (req_valid & req_ready). rsp_valid is first high in cycle A+1+WAIT_CYCLES.
- Earliest next acceptance: cycle after the RESP handshake edge, so the minimum request period is WAIT_CYCLES+2 cycles.
- Backpressure: rsp_ready=0 holds RESP indefinitely with outputs frozen; no further RAM access occurs.
- Reset mid-operation:
  - A store still in WAIT is dropped; RAM is unchanged.
  - A store already in RESP has completed its write.
- Changes on req_* inputs outside the accept cycle are ignored.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF with WAIT_CYCLES=2 -> req_ready low 3 cycles, rsp_valid high in cycle A+3, rsp_error=0; LW 0x10 -> rsp_rdata=0xDEADBEEF.
- SB addr 0x11 data 0x000000A5 over word 0xDEADBEEF -> LW 0x10 returns 0xDEADA5EF; LB 0x11 returns 0xFFFFFFA5; LBU 0x11 returns 0x000000A5.
- SH addr 0x12 data 0x00008001 -> LH 0x12 returns 0xFFFF8001; LHU 0x12 returns 0x00008001; LW 0x10 returns 0x8001A5EF.
- Errors:
  - LW 0x13 -> rsp_error=1, rsp_rdata=0.
  - SH 0x11 -> rsp_error=1; a following LW 0x10 is unchanged.
  - LW 4*DEPTH_WORDS -> rsp_error=1.
  - Load funct3=011 -> rsp_error=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/rsp_rdata stable, req_ready=0; release -> IDLE next cycle. Repeat with WAIT_CYCLES=0 -> rsp_valid in cycle A+1.
- Assert reset=0 during WAIT of SW 0x20 data 0x12345678 -> rsp_valid never asserts; after release, LW 0x20 returns the prior contents.
